// File: rtl/ram_arb_pkg.sv
// Shared definitions for the RAMControl bus arbiter: FSM encoding and the
// READ/WRITE op codes, which match RAMControl's ramInstruction.
package ram_arb_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWaitAcc,
    StWaitDone,
    StDone
  } arb_state_e;

  localparam logic RamRead  = 1'b0;
  localparam logic RamWrite = 1'b1;

endpackage

// File: rtl/ram_bus_arbiter_if.sv
// Requester-side and RAMControl-side signals of the arbiter. The arbiter
// connects through the slave modport; engines and RAMControl use master.
interface ram_bus_arbiter_if #(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned ADDR_W = 23,
  parameter int unsigned DATA_W = 16
);

  logic [NREQ-1:0]        req;
  logic [NREQ-1:0]        req_we;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ*DATA_W-1:0] req_wdata;
  logic [NREQ-1:0]        gnt;
  logic [NREQ-1:0]        ack;
  logic [DATA_W-1:0]      rdata;
  logic                   busy;
  logic                   err;

  logic                   ram_instr;
  logic                   ram_latch;
  logic [ADDR_W-1:0]      ram_addr;
  logic [DATA_W-1:0]      ram_wdata;
  logic [DATA_W-1:0]      ram_rdata;
  logic                   ram_ready;

  modport slave (
    input  req, req_we, req_addr, req_wdata, ram_rdata, ram_ready,
    output gnt, ack, rdata, busy, err, ram_instr, ram_latch, ram_addr, ram_wdata
  );

  modport master (
    output req, req_we, req_addr, req_wdata, ram_rdata, ram_ready,
    input  gnt, ack, rdata, busy, err, ram_instr, ram_latch, ram_addr, ram_wdata
  );

endinterface

// File: rtl/ram_bus_arbiter_rr_picker.sv
// Combinational round-robin select: searches upward from ptr_i+1 (mod NREQ)
// and returns the first requesting index as one-hot and as a binary index.
module rr_picker #(
  parameter int unsigned NREQ = 4,
  localparam int unsigned IdxW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IdxW-1:0] ptr_i,
  output logic            valid_o,
  output logic [NREQ-1:0] onehot_o,
  output logic [IdxW-1:0] idx_o
);

  logic [IdxW-1:0] cand;

  always_comb begin
    valid_o  = 1'b0;
    onehot_o = '0;
    idx_o    = '0;
    cand     = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = IdxW'((32'(ptr_i) + k) % NREQ);
      if (!valid_o && req_i[cand]) begin
        valid_o        = 1'b1;
        onehot_o[cand] = 1'b1;
        idx_o          = cand;
      end
    end
  end

endmodule

// File: rtl/ram_bus_arbiter.sv
// Round-robin arbiter sharing the single RAMControl port between GA engines.
// Optional watchdog abort is compiled in with `define RAM_ARB_WDOG_EN.
module ram_bus_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned NREQ        = 4,
  parameter int unsigned ADDR_W      = 23,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned WDOG_CYCLES = 1023
) (
  input  logic             clk,
  input  logic             rst_n,
  ram_bus_arbiter_if.slave bus
);

  localparam int unsigned IdxW = $clog2(NREQ);

  arb_state_e        state_q, state_d;
  logic [IdxW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0]   win_idx_q, win_idx_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic              instr_q, instr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic              pick_valid;
  logic [NREQ-1:0]   pick_onehot;
  logic [IdxW-1:0]   pick_idx;
  logic              timeout;

  logic [ADDR_W-1:0] addr_slice  [NREQ];
  logic [DATA_W-1:0] wdata_slice [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_slice
    assign addr_slice[i]  = bus.req_addr[i*ADDR_W +: ADDR_W];
    assign wdata_slice[i] = bus.req_wdata[i*DATA_W +: DATA_W];
  end

  rr_picker #(
    .NREQ (NREQ)
  ) u_picker (
    .req_i    (bus.req),
    .ptr_i    (rr_ptr_q),
    .valid_o  (pick_valid),
    .onehot_o (pick_onehot),
    .idx_o    (pick_idx)
  );

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    win_idx_d = win_idx_q;
    gnt_d     = gnt_q;
    instr_d   = instr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    unique case (state_q)
      StIdle: begin
        // Payload is latched at grant so a requester dropping req early is harmless.
        if (pick_valid && bus.ram_ready) begin
          gnt_d     = pick_onehot;
          win_idx_d = pick_idx;
          instr_d   = bus.req_we[pick_idx];
          addr_d    = addr_slice[pick_idx];
          wdata_d   = wdata_slice[pick_idx];
          state_d   = StIssue;
        end
      end
      StIssue: state_d = StWaitAcc;
      StWaitAcc: begin
        if (timeout)             state_d = StDone;
        else if (!bus.ram_ready) state_d = StWaitDone;
      end
      StWaitDone: begin
        if (timeout) begin
          state_d = StDone;
        end else if (bus.ram_ready) begin
          if (instr_q == RamRead) rdata_d = bus.ram_rdata;
          state_d = StDone;
        end
      end
      StDone: begin
        rr_ptr_d = win_idx_q;
        gnt_d    = '0;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      rr_ptr_q  <= IdxW'(NREQ - 1);
      win_idx_q <= '0;
      gnt_q     <= '0;
      instr_q   <= RamRead;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      win_idx_q <= win_idx_d;
      gnt_q     <= gnt_d;
      instr_q   <= instr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
    end
  end

`ifdef RAM_ARB_WDOG_EN
  localparam int unsigned WdogW = $clog2(WDOG_CYCLES + 1);

  logic [WdogW-1:0] wdog_q, wdog_d;
  logic             err_q, err_d;
  logic             waiting;

  assign waiting = (state_q == StWaitAcc) || (state_q == StWaitDone);
  // Fires on the cycle the count would reach WDOG_CYCLES.
  assign timeout = waiting && (wdog_q == WdogW'(WDOG_CYCLES - 1));

  always_comb begin
    wdog_d = wdog_q;
    err_d  = err_q | timeout;
    if (state_q == StIssue) wdog_d = '0;
    else if (waiting)       wdog_d = wdog_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wdog_q <= wdog_d;
      err_q  <= err_d;
    end
  end

  assign bus.err = err_q;
`else
  logic unused_wdog;
  assign unused_wdog = ^WDOG_CYCLES;
  assign timeout     = 1'b0;
  assign bus.err     = 1'b0;
`endif

  assign bus.gnt       = gnt_q;
  assign bus.ack       = (state_q == StDone) ? gnt_q : '0;
  assign bus.rdata     = rdata_q;
  assign bus.busy      = (state_q != StIdle);
  assign bus.ram_instr = instr_q;
  assign bus.ram_latch = (state_q == StIssue);
  assign bus.ram_addr  = addr_q;
  assign bus.ram_wdata = wdata_q;

endmodule
